// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue fetch stage buffering {pc, inst} pairs from a synchronous
// instruction memory and presenting two slots per cycle to the pair check stage.
module fetch_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3,
   parameter logic [12:0] RESET_PC = 13'd0
) (
   input  logic        CLK,
   input  logic        NRST,
   output logic        imem_req,
   output logic [9:0]  imem_addr,
   input  logic [63:0] imem_rdata,
   input  logic        redirect,
   input  logic [12:0] redirect_pc,
   input  logic        stall,
   input  logic        is_depend,
   output logic [12:0] pc1_out,
   output logic [12:0] pc2_out,
   output logic [31:0] inst1_out,
   output logic [31:0] inst2_out
);
   localparam logic [PTR_W:0] ZERO = '0;
   localparam logic [PTR_W:0] ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] TWO = (PTR_W+1)'(2);
   logic [44:0] mem [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0] count, pop_n, push_n;
   logic [12:0] fetch_pc, resp_pc;
   logic inflight, was_split;
   // two words of space are reserved for every read still in flight
   assign imem_req = NRST && !redirect && (int'(count) + (inflight ? 2 : 0) <= DEPTH - 2);
   assign imem_addr = fetch_pc[12:3];
   assign push_n = !inflight ? ZERO : resp_pc[2] ? ONE : TWO;
   assign pop_n = (stall || count == ZERO) ? ZERO : (was_split || count == ONE) ? ONE : TWO;
   assign {pc1_out, inst1_out} = (count != ZERO) ? mem[head] : '0;
   assign {pc2_out, inst2_out} = (!was_split && count >= TWO) ? mem[head + PTR_W'(1)] : '0;
   always_ff @(posedge CLK) begin
      if (!NRST) begin
         fetch_pc <= RESET_PC;
         head <= '0;
         tail <= '0;
         count <= '0;
         inflight <= 1'b0;
         was_split <= 1'b0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         head <= tail;
         count <= '0;
         inflight <= 1'b0;
         was_split <= 1'b0;
      end else begin
         if (imem_req) fetch_pc <= {fetch_pc[12:3] + 10'd1, 3'b000};
         if (imem_req) resp_pc <= fetch_pc;
         inflight <= imem_req;
         head <= head + pop_n[PTR_W-1:0];
         tail <= tail + push_n[PTR_W-1:0];
         count <= count + push_n - pop_n;
         if (!stall) was_split <= is_depend;
      end
   end
   // a misaligned target only contributes the upper word of its pair
   always_ff @(posedge CLK) begin
      if (NRST && !redirect && inflight) begin
         if (resp_pc[2]) mem[tail] <= {resp_pc, imem_rdata[63:32]};
         else begin
            mem[tail] <= {resp_pc, imem_rdata[31:0]};
            mem[tail + PTR_W'(1)] <= {resp_pc + 13'd4, imem_rdata[63:32]};
         end
      end
   end
endmodule
